// File: rtl/demo_all_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : demo_all_wb_arb
// Description : Two-requester round-robin arbiter onto a single Wishbone
//               master port, with address-map checking and an optional BUS
//               timeout enabled by DEMO_ALL_WB_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module demo_all_wb_arb #(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned MAP_SIZE = 32'h2100
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [1:0]  req_i,
    input  logic [1:0]  we_i,
    input  logic [27:0] adr_i,
    input  logic [63:0] wdat_i,
    output logic [1:0]  ack_o,
    output logic [1:0]  err_o,
    output logic [31:0] rdat_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [13:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam logic [31:0] c_MAP_LIMIT = MAP_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last;
    logic        r_gnt;
    logic        r_we;
    logic        r_cyc;
    logic [13:0] r_adr;
    logic [31:0] r_wdat;
    logic [31:0] r_rdat;
    logic [1:0]  r_ack;
    logic [1:0]  r_err;

    logic        w_gnt;
    logic        w_we;
    logic [13:0] w_adr;
    logic [31:0] w_wdat;
    logic        w_illegal;
    logic        w_load;
    logic        w_resp;
    logic        w_resp_err;
    logic        w_resp_gnt;
    logic        w_capture;
    logic        w_tmo_hit;

    // Under contention the requester that did not win last time is chosen.
    assign w_gnt     = (req_i == 2'b11) ? ~r_last : req_i[1];
    assign w_we      = we_i[w_gnt];
    assign w_adr     = w_gnt ? adr_i[27:14] : adr_i[13:0];
    assign w_wdat    = w_gnt ? wdat_i[63:32] : wdat_i[31:0];
    assign w_illegal = ({18'd0, w_adr} >= c_MAP_LIMIT) || (w_adr[1:0] != 2'b00);

`ifdef DEMO_ALL_WB_ARB_TIMEOUT_EN
    localparam int c_TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    logic [c_TMO_W-1:0] r_tmo;

    // Counts BUS cycles already spent; zero on the first BUS cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tmo <= '0;
        end else if (r_state != ST_BUS) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    assign w_tmo_hit = (r_state == ST_BUS) && (r_tmo == c_TMO_LAST);
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_resp      = 1'b0;
        w_resp_err  = 1'b0;
        w_resp_gnt  = r_gnt;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req_i) begin
                    w_load     = 1'b1;
                    w_resp_gnt = w_gnt;
                    if (w_illegal) begin
                        w_state_nxt = ST_RESP;
                        w_resp      = 1'b1;
                        w_resp_err  = 1'b1;
                    end else begin
                        w_state_nxt = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                // Error takes priority over a simultaneous acknowledge.
                if (wb_err_i || w_tmo_hit) begin
                    w_state_nxt = ST_RESP;
                    w_resp      = 1'b1;
                    w_resp_err  = 1'b1;
                end else if (wb_ack_i) begin
                    w_state_nxt = ST_RESP;
                    w_resp      = 1'b1;
                    w_capture   = ~r_we;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_gnt   <= 1'b0;
            r_we    <= 1'b0;
            r_cyc   <= 1'b0;
            r_adr   <= '0;
            r_wdat  <= '0;
            r_rdat  <= '0;
            r_ack   <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cyc   <= (w_state_nxt == ST_BUS);
            if (w_load) begin
                r_gnt  <= w_gnt;
                r_last <= w_gnt;
                r_we   <= w_we;
                r_adr  <= w_adr;
                r_wdat <= w_wdat;
            end
            if (w_capture) begin
                r_rdat <= wb_dat_i;
            end
            r_ack <= '0;
            r_err <= '0;
            if (w_resp) begin
                if (w_resp_err) begin
                    r_err[w_resp_gnt] <= 1'b1;
                end else begin
                    r_ack[w_resp_gnt] <= 1'b1;
                end
            end
        end
    end

    assign ack_o    = r_ack;
    assign err_o    = r_err;
    assign rdat_o   = r_rdat;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_cyc;
    assign wb_we_o  = r_cyc & r_we;
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_wdat;

endmodule
`default_nettype wire

// File: tb/tb_demo_all_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_demo_all_wb_arb
// Description : Randomised self-checking bench for demo_all_wb_arb with a
//               behavioural Wishbone slave and reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demo_all_wb_arb;

    localparam int unsigned TB_TMO = 8;
    localparam int unsigned TB_MAP = 32'h2100;
`ifdef DEMO_ALL_WB_ARB_TIMEOUT_EN
    localparam int HOLD = 5;
`else
    localparam int HOLD = 1001;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_i = '0;
    logic [1:0]  we_i = '0;
    logic [27:0] adr_i = '0;
    logic [63:0] wdat_i = '0;
    logic [1:0]  ack_o;
    logic [1:0]  err_o;
    logic [31:0] rdat_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [13:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;

    always #5 clk = ~clk;

    demo_all_wb_arb #(
        .TIMEOUT (TB_TMO),
        .MAP_SIZE(TB_MAP)
    ) u_dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .req_i   (req_i),
        .we_i    (we_i),
        .adr_i   (adr_i),
        .wdat_i  (wdat_i),
        .ack_o   (ack_o),
        .err_o   (err_o),
        .rdat_o  (rdat_o),
        .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o),
        .wb_we_o (wb_we_o),
        .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i)
    );

    int checks = 0;
    int errors = 0;

    // Slave configuration and bus monitor state
    int          slv_dly = 0;
    bit          slv_err = 1'b0;
    bit          slv_both = 1'b0;
    logic [31:0] slv_dat = '0;
    int          cyc_seen = 0;
    int          resp_cnt = 0;
    int          stab_bad = 0;
    logic [13:0] cap_adr = '0;
    logic        cap_we = 1'b0;
    logic [31:0] cap_dat = '0;
    logic [46:0] prev_bus = '0;
    bit          hit;

    // Reference model state
    int          last_g = 1;
    logic [31:0] exp_rdat = '0;

    always @(negedge clk) begin
        if ((ack_o | err_o) != 2'b00) resp_cnt++;
        if (wb_cyc_o && wb_stb_o) begin
            cyc_seen++;
            if (cyc_seen == 1) begin
                cap_adr = wb_adr_o;
                cap_we  = wb_we_o;
                cap_dat = wb_dat_o;
            end else if ({wb_we_o, wb_adr_o, wb_dat_o} !== prev_bus) begin
                stab_bad++;
            end
            prev_bus = {wb_we_o, wb_adr_o, wb_dat_o};
            hit      = (slv_dly >= 0) && (cyc_seen == slv_dly + 1);
            wb_ack_i = hit && (!slv_err || slv_both);
            wb_err_i = hit && slv_err;
            wb_dat_i = hit ? slv_dat : $urandom;
        end else begin
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [13:0] a);
        return (32'(a) < TB_MAP) && ((a % 4) == 0);
    endfunction

    task automatic drive(input int r, input bit on, input bit we,
                         input logic [13:0] adr, input logic [31:0] wd);
        req_i[r] = on;
        we_i[r]  = we;
        if (r == 0) begin
            adr_i[13:0]  = adr;
            wdat_i[31:0] = wd;
        end else begin
            adr_i[27:14]  = adr;
            wdat_i[63:32] = wd;
        end
    endtask

    task automatic wait_resp(output int lat);
        bit found = 1'b0;
        lat = -1;
        for (int k = 1; k <= 3000 && !found; k++) begin
            @(negedge clk);
            if ((ack_o | err_o) != 2'b00) begin
                lat   = k;
                found = 1'b1;
            end
        end
    endtask

    task automatic do_txn(input int r, input bit we, input logic [13:0] adr,
                          input logic [31:0] wd, input int dly, input bit serr,
                          input bit sboth, input logic [31:0] sdat);
        int lat;
        int exp_lat;
        int exp_cyc;
        bit ok;
        bit fail_resp;
        logic [1:0] exp_ack;
        logic [1:0] exp_err;
        slv_dly  = dly;
        slv_err  = serr;
        slv_both = sboth;
        slv_dat  = sdat;
        cyc_seen = 0;
        drive(r, 1'b1, we, adr, wd);
        wait_resp(lat);
        ok        = legal(adr);
        fail_resp = !ok || serr || (dly < 0);
        exp_cyc   = !ok ? 0 : ((dly < 0) ? int'(TB_TMO) : dly + 1);
        exp_lat   = exp_cyc + 1;
        exp_ack   = fail_resp ? 2'b00 : 2'(1 << r);
        exp_err   = fail_resp ? 2'(1 << r) : 2'b00;
        last_g    = r;
        if (!fail_resp && !we) exp_rdat = sdat;
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("ack_o", 64'(ack_o), 64'(exp_ack));
        chk("err_o", 64'(err_o), 64'(exp_err));
        chk("cyc_cycles", 64'(cyc_seen), 64'(exp_cyc));
        chk("rdat_o", 64'(rdat_o), 64'(exp_rdat));
        if (ok) begin
            chk("wb_adr", 64'(cap_adr), 64'(adr));
            chk("wb_we", 64'(cap_we), 64'(we));
            if (we) chk("wb_dat", 64'(cap_dat), 64'(wd));
        end
        drive(r, 1'b0, 1'b0, 14'd0, 32'd0);
        @(negedge clk);
        chk("pulse_len", 64'(ack_o | err_o), 64'd0);
    endtask

    initial begin
        int lat;
        int rc;
        int g;
        int r;
        bit we;
        logic [13:0] a;

        #1;
        chk("rst_cyc", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'd0);
        chk("rst_resp", 64'({ack_o, err_o}), 64'd0);
        chk("rst_bus", 64'({wb_adr_o, wb_dat_o}), 64'd0);
        chk("rst_rdat", 64'(rdat_o), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed read with a two-cycle slave wait
        do_txn(0, 1'b0, 14'h4, 32'd0, 2, 1'b0, 1'b0, 32'h123);
        chk("rdat_123", 64'(rdat_o), 64'h123);

        for (int i = 0; i < 24; i++) begin
            r  = int'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0, 1:    a = 14'($urandom_range(0, TB_MAP / 4 - 1) * 4);
                2:       a = 14'($urandom_range(TB_MAP, 16383));
                default: a = 14'($urandom_range(0, TB_MAP / 4 - 1) * 4 + $urandom_range(1, 3));
            endcase
            do_txn(r, we, a, $urandom, int'($urandom_range(0, 3)),
                   ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), $urandom);
        end

        // Illegal addresses never reach the bus
        do_txn(1, 1'b1, 14'h2100, $urandom, 0, 1'b0, 1'b0, $urandom);
        do_txn(0, 1'b1, 14'h0006, $urandom, 0, 1'b0, 1'b0, $urandom);

        // Slave error on a write leaves rdat_o untouched
        do_txn(1, 1'b1, 14'h1000, $urandom, 1, 1'b1, 1'b0, $urandom);

`ifdef DEMO_ALL_WB_ARB_TIMEOUT_EN
        do_txn(0, 1'b0, 14'h100, 32'd0, -1, 1'b0, 1'b0, $urandom);
`endif

        // Silent slave, then reset in the middle of the transfer
        slv_dly  = -1;
        cyc_seen = 0;
        rc       = resp_cnt;
        drive(0, 1'b1, 1'b0, 14'h200, 32'd0);
        repeat (HOLD) @(negedge clk);
        chk("silent_cyc", 64'(cyc_seen), 64'(HOLD - 1));
        chk("silent_no_resp", 64'(resp_cnt - rc), 64'd0);
        chk("silent_cyc_high", 64'(wb_cyc_o), 64'd1);
        last_g = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cyc", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'd0);
        chk("async_rst_out", 64'({ack_o, err_o, wb_adr_o, wb_dat_o, rdat_o}), 64'd0);
        drive(0, 1'b0, 1'b0, 14'd0, 32'd0);
        exp_rdat = '0;
        last_g   = 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rc    = resp_cnt;
        repeat (3) @(negedge clk);
        chk("killed_no_resp", 64'(resp_cnt - rc), 64'd0);

        // Contention: both requesters hold their request
        slv_dly = 0;
        slv_err = 1'b0;
        drive(0, 1'b1, 1'b0, 14'h10, 32'd0);
        drive(1, 1'b1, 1'b0, 14'h20, 32'd0);
        for (int k = 0; k < 4; k++) begin
            slv_dat  = $urandom;
            cyc_seen = 0;
            wait_resp(lat);
            g        = 1 - last_g;
            last_g   = g;
            exp_rdat = slv_dat;
            chk("rr_grant", 64'(ack_o), 64'(1 << g));
            chk("rr_latency", 64'(lat), 64'((k == 0) ? 2 : 3));
            chk("rr_rdat", 64'(rdat_o), 64'(exp_rdat));
        end
        drive(0, 1'b0, 1'b0, 14'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 14'd0, 32'd0);
        repeat (2) @(negedge clk);

        chk("bus_stable", 64'(stab_bad), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demo_all_wb_arb.md
DEMO_ALL_WB_ARB -- requirements
Module: demo_all_wb_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: the number of BUS-state cycles without slave ack/err before the transfer is aborted.
REQ-002 SHALL have parameter MAP_SIZE, default 8448 ('h2100): the upper exclusive byte-address limit of the demo_all map.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port req_i, input, 2 bits: per-requester request; bit n belongs to requester n.
REQ-006 SHALL have port we_i, input, 2 bits: per-requester write enable.
REQ-007 SHALL have port adr_i, input, 28 bits: byte address; requester n uses bits [14n+13:14n].
REQ-008 SHALL have port wdat_i, input, 64 bits: write data; requester n uses bits [32n+31:32n].
REQ-009 SHALL have port ack_o, output, 2 bits: one-cycle completion pulse per requester.
REQ-010 SHALL have port err_o, output, 2 bits: one-cycle error pulse per requester.
REQ-011 SHALL have port rdat_o, output, 32 bits: registered read data, shared by both requesters.
REQ-012 SHALL have port wb_cyc_o, output, 1 bit: Wishbone cycle.
REQ-013 SHALL have port wb_stb_o, output, 1 bit: Wishbone strobe.
REQ-014 SHALL have port wb_we_o, output, 1 bit: Wishbone write enable.
REQ-015 SHALL have port wb_adr_o, output, 14 bits: Wishbone byte address.
REQ-016 SHALL have port wb_dat_o, output, 32 bits: Wishbone write data.
REQ-017 SHALL have port wb_dat_i, input, 32 bits: Wishbone read data.
REQ-018 SHALL have port wb_ack_i, input, 1 bit: Wishbone acknowledge.
REQ-019 SHALL have port wb_err_i, input, 1 bit: Wishbone error.

Function
REQ-020 SHALL implement an FSM with states IDLE, BUS and RESP.
REQ-021 IDLE: on any req_i bit high, SHALL latch the granted requester's we/adr/wdat and move to BUS, or to RESP with error if the address is illegal.
REQ-022 An address is illegal when adr >= MAP_SIZE or adr[1:0] != 0; an illegal address SHALL produce no Wishbone cycle.
REQ-023 Arbitration SHALL be round-robin: if both req_i bits are high, the requester not granted last wins; a single request is granted directly.
REQ-024 The last-grant register SHALL reset to 1, so requester 0 wins the first contention.
REQ-025 BUS: wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o and wb_dat_o SHALL be registered and asserted the cycle after the request is sampled.
REQ-026 BUS: those outputs SHALL be held stable until wb_ack_i or wb_err_i.
REQ-027 BUS: on wb_ack_i, SHALL capture wb_dat_i into rdat_o on reads and move to RESP with ok status.
REQ-028 BUS: on wb_err_i, SHALL move to RESP with error status; if both are high, err SHALL win.
REQ-029 RESP: wb_cyc_o and wb_stb_o SHALL be 0, and exactly one of ack_o[g] or err_o[g] SHALL pulse for one cycle; the next state is IDLE.
REQ-030 Latency for a legal access: req sampled at cycle N, cyc at N+1, slave ack at M, ack_o at M+1; an illegal access gives err_o at N+1.
REQ-031 A requester SHALL hold req/we/adr/wdat until its ack/err; req still high in IDLE after the response SHALL be a new request.
REQ-032 If req drops mid-transfer, the transfer SHALL still complete and the ack/err pulse SHALL still be issued.
REQ-033 rdat_o SHALL keep its last value; a write SHALL not alter it.

Reset
REQ-034 Asserting rst_n_i low SHALL immediately force state IDLE, all outputs 0, rdat_o 0, timeout counter 0 and last-grant 1, including mid-transfer.
REQ-035 No ack/err SHALL be issued for a transfer killed by reset.

Configuration
REQ-036 With macro DEMO_ALL_WB_ARB_TIMEOUT_EN defined, a counter SHALL be cleared on BUS entry and incremented each BUS cycle.
REQ-037 With DEMO_ALL_WB_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT without ack/err, the block SHALL go to RESP with error and drop cyc/stb.
REQ-038 Without DEMO_ALL_WB_ARB_TIMEOUT_EN, BUS SHALL wait indefinitely and no counter logic SHALL exist.

Verification
REQ-039 Req0 read 'h4, slave acks after 2 cycles with 'h123 -> wb_cyc_o high for 3 cycles, ack_o=01 one cycle later, rdat_o='h123.
REQ-040 Both requesters request simultaneously after reset and hold req -> grants in order 0,1,0,1, never two back-to-back for one requester.
REQ-041 Req1 write 'h2100 and req0 write 'h6 -> err_o pulses each, wb_cyc_o never asserted.
REQ-042 Slave asserts wb_err_i on a write to 'h1000 -> err_o for that requester, rdat_o unchanged.
REQ-043 With DEMO_ALL_WB_ARB_TIMEOUT_EN and TIMEOUT=8, slave silent -> cyc high 8 cycles then err_o; without the macro, cyc stays high for 1000 cycles.
REQ-044 Pull rst_n_i low during BUS -> all outputs 0 asynchronously; after release, the next contention is granted to requester 0.
